node_pkt_queue: RTL and testbench

- Outbound packet buffer between a processor node and router_core.
- Accepts 29-bit packets from the node, stores them in a FIFO, and presents the head to router_core on Packet_From_Node/Packet_From_Node_Valid.
- Pops the head once per Core_Load_Ack assertion.
- Lets the node keep issuing packets while the router waits for the token.

---
 rtl/router_pkg.sv | 16 +
 rtl/pkt_fifo_mem.sv | 63 ++++++
 rtl/node_pkt_queue.sv | 111 +++++++++++
 tb/tb_node_pkt_queue.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: packet field layout and the node queue FSM encoding.
package router_pkg;
  localparam int PKT_W     = 29;
  localparam int ADDR_W    = 4;
  localparam int PAYLOAD_W = 24;

  localparam int DEST_HI  = 28;
  localparam int DEST_LO  = 25;
  localparam int TYPE_BIT = 24;

  // Head-presentation FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_EMPTY   = 2'd0;
  localparam state_t ST_PRESENT = 2'd1;
  localparam state_t ST_WAIT    = 2'd2;
endpackage

// File: rtl/pkt_fifo_mem.sv
// Packet storage for node_pkt_queue: circular buffer with wrapping pointers
// and a count one bit wider than the pointers so full and empty differ.
module pkt_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 29
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem[rd_ptr_q];
  assign count_o = count_q;

  // Next pointers and occupancy; power-of-two depth lets pointers wrap on overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since reads are gated by count
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/node_pkt_queue.sv
// Outbound packet queue from a processor node to router_core.
// Presents the FIFO head with a registered valid/data pair and pops exactly
// once per Core_Load_Ack assertion.
// Optional: define NODE_PKT_SELF_FILTER_EN to discard packets addressed to
// R_ADDR and expose the Self_Drop pulse.
module node_pkt_queue
  import router_pkg::*;
#(
  parameter int              DEPTH  = 4,
  parameter logic [3:0]      R_ADDR = 4'b0000,
  parameter int              PKT_W  = 29
) (
  input  logic                     Clk_R,
  input  logic                     Rst,
  input  logic [PKT_W-1:0]         Node_Packet,
  input  logic                     Node_Packet_Valid,
  output logic                     Node_Packet_Ready,
  input  logic                     Core_Load_Ack,
  output logic [PKT_W-1:0]         Packet_From_Node,
  output logic                     Packet_From_Node_Valid,
  output logic [$clog2(DEPTH):0]   Fifo_Count,
  output logic                     Overflow
`ifdef NODE_PKT_SELF_FILTER_EN
  ,
  output logic                     Self_Drop
`endif
);
  logic [PKT_W-1:0]       head;
  logic [$clog2(DEPTH):0] count;
  logic                   full, empty;
  logic                   push, pop;
  state_t                 state_q, state_d;
  logic [PKT_W-1:0]       pkt_q, pkt_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;

  assign Node_Packet_Ready = !full;

`ifdef NODE_PKT_SELF_FILTER_EN
  logic self_hit;
  logic self_drop_q, self_drop_d;
  assign self_hit    = (Node_Packet[DEST_HI:DEST_LO] == R_ADDR);
  assign push        = Node_Packet_Valid && Node_Packet_Ready && !self_hit;
  assign self_drop_d = Node_Packet_Valid && Node_Packet_Ready && self_hit;
  assign Self_Drop   = self_drop_q;

  // One-cycle pulse for each self-addressed packet swallowed
  always_ff @(posedge Clk_R) begin
    if (Rst) self_drop_q <= 1'b0;
    else     self_drop_q <= self_drop_d;
  end
`else
  // R_ADDR only matters when the self-filter is built in
  logic unused_raddr;
  assign unused_raddr = ^R_ADDR;
  assign push         = Node_Packet_Valid && Node_Packet_Ready;
`endif

  assign pop = (state_q == ST_PRESENT) && Core_Load_Ack;

  pkt_fifo_mem #(.DEPTH(DEPTH), .W(PKT_W)) u_mem (
    .clk_i   (Clk_R),
    .rst_i   (Rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (Node_Packet),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Presentation FSM; WAIT holds off re-presenting until the ack is released
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY:   if (!empty) state_d = ST_PRESENT;
      ST_PRESENT: if (Core_Load_Ack) state_d = ST_WAIT;
      ST_WAIT:    if (!Core_Load_Ack) state_d = empty ? ST_EMPTY : ST_PRESENT;
      default:    state_d = ST_EMPTY;
    endcase
  end

  // Output next-state: data latched only on entry to PRESENT so it holds otherwise
  always_comb begin
    pkt_d   = pkt_q;
    valid_d = (state_d == ST_PRESENT);
    ovf_d   = ovf_q || (Node_Packet_Valid && !Node_Packet_Ready);
    if (state_q != ST_PRESENT && state_d == ST_PRESENT) pkt_d = head;
  end

  // FSM and output registers
  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      state_q <= ST_EMPTY;
      pkt_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Packet_From_Node       = pkt_q;
  assign Packet_From_Node_Valid = valid_q;
  assign Fifo_Count             = count;
  assign Overflow               = ovf_q;
endmodule

// File: tb/tb_node_pkt_queue.sv
// Self-checking bench for node_pkt_queue: directed scenarios plus a random
// run checked against a queue-based model of the packet buffer.
module tb_node_pkt_queue;
  localparam int         DEPTH  = 4;
  localparam logic [3:0] R_ADDR = 4'b0000;
  localparam int         PKT_W  = 29;

  logic             Clk_R = 1'b0;
  logic             Rst;
  logic [PKT_W-1:0] Node_Packet;
  logic             Node_Packet_Valid;
  logic             Node_Packet_Ready;
  logic             Core_Load_Ack;
  logic [PKT_W-1:0] Packet_From_Node;
  logic             Packet_From_Node_Valid;
  logic [2:0]       Fifo_Count;
  logic             Overflow;
`ifdef NODE_PKT_SELF_FILTER_EN
  logic             Self_Drop;
  localparam bit    FILTER = 1'b1;
`else
  localparam bit    FILTER = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  node_pkt_queue #(.DEPTH(DEPTH), .R_ADDR(R_ADDR), .PKT_W(PKT_W)) dut (
    .Clk_R                  (Clk_R),
    .Rst                    (Rst),
    .Node_Packet            (Node_Packet),
    .Node_Packet_Valid      (Node_Packet_Valid),
    .Node_Packet_Ready      (Node_Packet_Ready),
    .Core_Load_Ack          (Core_Load_Ack),
    .Packet_From_Node       (Packet_From_Node),
    .Packet_From_Node_Valid (Packet_From_Node_Valid),
    .Fifo_Count             (Fifo_Count),
    .Overflow               (Overflow)
`ifdef NODE_PKT_SELF_FILTER_EN
    ,
    .Self_Drop              (Self_Drop)
`endif
  );

  always #5 Clk_R = ~Clk_R;

  function automatic logic [PKT_W-1:0] mk(input logic [3:0] dest, input logic [23:0] pl);
    return {dest, 1'b0, pl};
  endfunction

  task automatic tick;
    @(posedge Clk_R);
    #1;
  endtask

  task automatic do_reset;
    Rst = 1'b1; Node_Packet_Valid = 1'b0; Node_Packet = '0; Core_Load_Ack = 1'b0;
    tick; tick;
    Rst = 1'b0;
  endtask

  task automatic push1(input logic [PKT_W-1:0] p);
    Node_Packet = p; Node_Packet_Valid = 1'b1;
    tick;
    Node_Packet_Valid = 1'b0;
  endtask

  // Waits (bounded) for a presented head, then acknowledges it for one cycle
  task automatic do_pop(output logic [PKT_W-1:0] p, output bit ok);
    ok = 1'b0; p = '0;
    for (int i = 0; i < 10 && !Packet_From_Node_Valid; i++) tick;
    if (Packet_From_Node_Valid) begin
      ok = 1'b1; p = Packet_From_Node;
      Core_Load_Ack = 1'b1; tick;
      Core_Load_Ack = 1'b0; tick;
    end
  endtask

  task automatic wait_valid(output bit ok);
    for (int i = 0; i < 10 && !Packet_From_Node_Valid; i++) tick;
    ok = Packet_From_Node_Valid;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (Packet_From_Node_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", Packet_From_Node_Valid); end
    checks++; if (Packet_From_Node !== '0) begin errors++; $display("FAIL reset_pkt got %h want 0", Packet_From_Node); end
    checks++; if (Fifo_Count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", Fifo_Count); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", Overflow); end
    checks++; if (Node_Packet_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", Node_Packet_Ready); end
  endtask

  task automatic test_single_push;
    do_reset;
    push1(29'h200002A);
    checks++; if (Fifo_Count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", Fifo_Count); end
    checks++; if (Packet_From_Node_Valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0b want 0", Packet_From_Node_Valid); end
    tick;
    checks++; if (Packet_From_Node_Valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", Packet_From_Node_Valid); end
    checks++; if (Packet_From_Node !== 29'h200002A) begin errors++; $display("FAIL single_pkt got %h want 200002a", Packet_From_Node); end
  endtask

  task automatic test_ack_hold;
    bit ok;
    do_reset;
    push1(mk(4'd1, 24'd11));
    push1(mk(4'd1, 24'd22));
    wait_valid(ok);
    checks++; if (!ok || Packet_From_Node !== mk(4'd1, 24'd11)) begin errors++; $display("FAIL hold_first got %h want %h", Packet_From_Node, mk(4'd1, 24'd11)); end
    Core_Load_Ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++; if (Fifo_Count !== 3'd1 || Packet_From_Node_Valid !== 1'b0) begin errors++; $display("FAIL hold_cycle%0d count %0d valid %0b want 1/0", i, Fifo_Count, Packet_From_Node_Valid); end
    end
    Core_Load_Ack = 1'b0;
    wait_valid(ok);
    checks++; if (!ok || Packet_From_Node !== mk(4'd1, 24'd22)) begin errors++; $display("FAIL hold_second got %h want %h", Packet_From_Node, mk(4'd1, 24'd22)); end
    checks++; if (Fifo_Count !== 3'd1) begin errors++; $display("FAIL hold_count got %0d want 1", Fifo_Count); end
  endtask

  task automatic test_full_overflow;
    logic [PKT_W-1:0] p; bit ok;
    do_reset;
    for (int i = 1; i <= 4; i++) push1(mk(4'd1, 24'(i)));
    checks++; if (Node_Packet_Ready !== 1'b0 || Fifo_Count !== 3'd4) begin errors++; $display("FAIL full_state ready %0b count %0d want 0/4", Node_Packet_Ready, Fifo_Count); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL full_ovf_early got %0b want 0", Overflow); end
    push1(mk(4'd1, 24'd5));
    checks++; if (Overflow !== 1'b1 || Fifo_Count !== 3'd4) begin errors++; $display("FAIL full_ovf ovf %0b count %0d want 1/4", Overflow, Fifo_Count); end
    for (int i = 1; i <= 4; i++) begin
      do_pop(p, ok);
      checks++; if (!ok || p !== mk(4'd1, 24'(i))) begin errors++; $display("FAIL drain%0d got %h ok %0b want %h", i, p, ok, mk(4'd1, 24'(i))); end
    end
    checks++; if (Fifo_Count !== 3'd0 || Overflow !== 1'b1) begin errors++; $display("FAIL drain_end count %0d ovf %0b want 0/1", Fifo_Count, Overflow); end
  endtask

  task automatic test_back_to_back;
    logic [PKT_W-1:0] q[$];
    logic [PKT_W-1:0] p, np; bit ok;
    do_reset;
    push1(mk(4'd1, 24'd200)); q.push_back(mk(4'd1, 24'd200));
    push1(mk(4'd1, 24'd201)); q.push_back(mk(4'd1, 24'd201));
    for (int i = 0; i < 6; i++) begin
      wait_valid(ok);
      checks++; if (!ok || Packet_From_Node !== q[0]) begin errors++; $display("FAIL b2b_head%0d got %h want %h", i, Packet_From_Node, q[0]); end
      np = mk(4'd1, 24'(100 + i));
      Node_Packet = np; Node_Packet_Valid = 1'b1; Core_Load_Ack = 1'b1;
      tick;
      void'(q.pop_front()); q.push_back(np);
      checks++; if (Fifo_Count !== 3'd2) begin errors++; $display("FAIL b2b_count%0d got %0d want 2", i, Fifo_Count); end
      Node_Packet_Valid = 1'b0; Core_Load_Ack = 1'b0;
      tick;
    end
    while (q.size() > 0) begin
      do_pop(p, ok);
      checks++; if (!ok || p !== q[0]) begin errors++; $display("FAIL b2b_drain got %h want %h", p, q[0]); end
      void'(q.pop_front());
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    do_reset;
    for (int i = 0; i < 3; i++) push1(mk(4'd1, 24'(10 + i)));
    wait_valid(ok);
    Core_Load_Ack = 1'b1;
    tick;
    checks++; if (Fifo_Count !== 3'd2) begin errors++; $display("FAIL mid_count got %0d want 2", Fifo_Count); end
    Rst = 1'b1;
    tick;
    Rst = 1'b0;
    checks++; if (Packet_From_Node_Valid !== 1'b0 || Packet_From_Node !== '0) begin errors++; $display("FAIL mid_rst_out valid %0b pkt %h want 0/0", Packet_From_Node_Valid, Packet_From_Node); end
    checks++; if (Fifo_Count !== 3'd0 || Overflow !== 1'b0 || Node_Packet_Ready !== 1'b1) begin errors++; $display("FAIL mid_rst_state count %0d ovf %0b rdy %0b want 0/0/1", Fifo_Count, Overflow, Node_Packet_Ready); end
    tick; tick;
    checks++; if (Packet_From_Node_Valid !== 1'b0) begin errors++; $display("FAIL mid_idle_valid got %0b want 0", Packet_From_Node_Valid); end
    Core_Load_Ack = 1'b0;
    push1(mk(4'd1, 24'd69));
    wait_valid(ok);
    checks++; if (!ok || Packet_From_Node !== mk(4'd1, 24'd69)) begin errors++; $display("FAIL mid_repush got %h want %h", Packet_From_Node, mk(4'd1, 24'd69)); end
  endtask

`ifdef NODE_PKT_SELF_FILTER_EN
  task automatic test_self_filter;
    do_reset;
    Node_Packet = mk(4'd0, 24'd69); Node_Packet_Valid = 1'b1;
    tick;
    Node_Packet_Valid = 1'b0;
    checks++; if (Self_Drop !== 1'b1 || Fifo_Count !== 3'd0) begin errors++; $display("FAIL self_drop pulse %0b count %0d want 1/0", Self_Drop, Fifo_Count); end
    tick;
    checks++; if (Self_Drop !== 1'b0) begin errors++; $display("FAIL self_drop_end got %0b want 0", Self_Drop); end
    push1(mk(4'd2, 24'd7));
    checks++; if (Self_Drop !== 1'b0 || Fifo_Count !== 3'd1) begin errors++; $display("FAIL self_other pulse %0b count %0d want 0/1", Self_Drop, Fifo_Count); end
  endtask
`endif

  // Random traffic: model is a bounded packet queue; a pop happens whenever
  // the head is on offer and the router acknowledges it.
  task automatic test_random;
    logic [PKT_W-1:0] q[$];
    logic [PKT_W-1:0] np;
    bit ovf_m, nv, ack, pre_valid, rdy_m, self_m, push_m;
    do_reset;
    ovf_m = 1'b0;
    for (int c = 0; c < 400; c++) begin
      nv  = ($urandom_range(0, 1) == 1);
      np  = PKT_W'($urandom);
      ack = ($urandom_range(0, 4) < 2);
      Node_Packet = np; Node_Packet_Valid = nv; Core_Load_Ack = ack;
      pre_valid = Packet_From_Node_Valid;
      if (pre_valid) begin
        checks++; if (q.size() == 0 || Packet_From_Node !== q[0]) begin errors++; $display("FAIL rnd_head c%0d got %h model size %0d", c, Packet_From_Node, q.size()); end
      end
      rdy_m  = (q.size() < DEPTH);
      self_m = FILTER && (np[28:25] == R_ADDR);
      push_m = nv && rdy_m && !self_m;
      if (nv && !rdy_m) ovf_m = 1'b1;
      tick;
      if (pre_valid && ack && q.size() > 0) void'(q.pop_front());
      if (push_m) q.push_back(np);
      checks++; if (Fifo_Count !== 3'(q.size())) begin errors++; $display("FAIL rnd_count c%0d got %0d want %0d", c, Fifo_Count, q.size()); end
      checks++; if (Node_Packet_Ready !== (q.size() < DEPTH) || Overflow !== ovf_m) begin errors++; $display("FAIL rnd_flags c%0d rdy %0b ovf %0b want %0b/%0b", c, Node_Packet_Ready, Overflow, (q.size() < DEPTH), ovf_m); end
`ifdef NODE_PKT_SELF_FILTER_EN
      checks++; if (Self_Drop !== (nv && rdy_m && self_m)) begin errors++; $display("FAIL rnd_selfdrop c%0d got %0b want %0b", c, Self_Drop, (nv && rdy_m && self_m)); end
`endif
    end
    Node_Packet_Valid = 1'b0; Core_Load_Ack = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single_push;
    test_ack_hold;
    test_full_overflow;
    test_back_to_back;
    test_reset_mid;
`ifdef NODE_PKT_SELF_FILTER_EN
    test_self_filter;
`endif
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
